// File: rtl/fpdiv_seq.sv
// fpdiv_seq: start/done sequencer for the Goldschmidt divider datapath.
// One accepted start walks the multiplier through the initial-approximation
// pass (N then D), ITER-1 refinement passes (A then B register), and a final
// remainder/rounding step, then pulses done for one cycle.
// Every output is a flop loaded from the decode of the next state, so the
// selects and enables change only on clock edges and never see an input
// through combinational logic.
module fpdiv_seq #(
  parameter int ITER = 6,
  parameter int CW   = $clog2(ITER + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          kill,
  input  logic          rm_in,
  output logic [1:0]    sel_mux3,
  output logic [1:0]    sel_mux4,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic          rm,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  // The pass counter must be able to hold ITER, and the schedule needs at
  // least one refinement pass after the initial approximation.
  if (ITER < 2 || ITER > 15) begin : g_iter_range
    $error("fpdiv_seq: ITER must be in 2..15");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IA_N = 3'd1,
    S_IA_D = 3'd2,
    S_IT_N = 3'd3,
    S_IT_D = 3'd4,
    S_REM  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  // Multiplier operand-B source (sel_mux3).
  localparam logic [1:0] B_IA  = 2'b00;
  localparam logic [1:0] B_C   = 2'b01;
  localparam logic [1:0] B_REM = 2'b10;

  // Multiplier operand-A source (sel_mux4).
  localparam logic [1:0] A_N    = 2'b00;
  localparam logic [1:0] A_D    = 2'b01;
  localparam logic [1:0] A_AREG = 2'b10;
  localparam logic [1:0] A_BREG = 2'b11;

  localparam logic [CW-1:0] ITER_LAST = CW'(ITER);
  localparam logic [CW-1:0] ITER_ONE  = CW'(1);

  typedef struct packed {
    logic [1:0] sel3;
    logic [1:0] sel4;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic       busy;
    logic       done;
  } ctl_t;

  state_e  state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic    rm_q, rm_d;
  ctl_t    ctl_q;

  // Control word for each state; at most one load enable is set per state.
  function automatic ctl_t decode(input state_e s);
    ctl_t c;
    c = '0;
    unique case (s)
      S_IA_N: begin
        c.sel4 = A_N;    c.sel3 = B_IA;  c.en_a   = 1'b1; c.busy = 1'b1;
      end
      S_IA_D: begin
        c.sel4 = A_D;    c.sel3 = B_IA;  c.en_b   = 1'b1; c.busy = 1'b1;
      end
      S_IT_N: begin
        c.sel4 = A_AREG; c.sel3 = B_C;   c.en_a   = 1'b1; c.busy = 1'b1;
      end
      S_IT_D: begin
        c.sel4 = A_BREG; c.sel3 = B_C;   c.en_b   = 1'b1; c.busy = 1'b1;
      end
      S_REM: begin
        c.sel4 = A_AREG; c.sel3 = B_REM; c.en_rem = 1'b1; c.busy = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state, pass counter and rounding-mode capture.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rm_d    = rm_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Start is only looked at here; kill is meaningless with nothing
        // in flight, so start wins when both are high in DONE.
        if (start) begin
          state_d = S_IA_N;
          iter_d  = ITER_ONE;
          rm_d    = rm_in;
        end else begin
          state_d = S_IDLE;
          iter_d  = '0;
        end
      end
      S_IA_N: begin
        if (kill) begin
          state_d = S_IDLE;
          iter_d  = '0;
        end else begin
          state_d = S_IA_D;
        end
      end
      S_IA_D: begin
        if (kill) begin
          state_d = S_IDLE;
          iter_d  = '0;
        end else begin
          state_d = S_IT_N;
          iter_d  = iter_q + ITER_ONE;
        end
      end
      S_IT_N: begin
        if (kill) begin
          state_d = S_IDLE;
          iter_d  = '0;
        end else begin
          state_d = S_IT_D;
        end
      end
      S_IT_D: begin
        if (kill) begin
          state_d = S_IDLE;
          iter_d  = '0;
        end else if (iter_q == ITER_LAST) begin
          state_d = S_REM;
          iter_d  = '0;
        end else begin
          state_d = S_IT_N;
          iter_d  = iter_q + ITER_ONE;
        end
      end
      S_REM: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
        iter_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
    endcase
  end

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      rm_q    <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      rm_q    <= rm_d;
      ctl_q   <= decode(state_d);
    end
  end

  assign sel_mux3 = ctl_q.sel3;
  assign sel_mux4 = ctl_q.sel4;
  assign en_a     = ctl_q.en_a;
  assign en_b     = ctl_q.en_b;
  assign en_rem   = ctl_q.en_rem;
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign rm       = rm_q;
  assign iter     = iter_q;

endmodule

// File: tb/tb_fpdiv_seq.sv
// Bench for fpdiv_seq: three instances (ITER = 6, 2, 15) share one set of
// inputs. Each is tracked by a phase-count model of the schedule, plus
// directed scenarios with hand-derived literal expectations.
module tb_fpdiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, kill, rm_in;

  logic [1:0] a_s3, a_s4, b_s3, b_s4, c_s3, c_s4;
  logic a_ea, a_eb, a_er, a_rm, a_bz, a_dn;
  logic b_ea, b_eb, b_er, b_rm, b_bz, b_dn;
  logic c_ea, c_eb, c_er, c_rm, c_bz, c_dn;
  logic [2:0] a_it;
  logic [1:0] b_it;
  logic [3:0] c_it;

  fpdiv_seq #(.ITER(6)) u6 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .rm_in(rm_in),
    .sel_mux3(a_s3), .sel_mux4(a_s4), .en_a(a_ea), .en_b(a_eb), .en_rem(a_er),
    .rm(a_rm), .busy(a_bz), .done(a_dn), .iter(a_it));

  fpdiv_seq #(.ITER(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .rm_in(rm_in),
    .sel_mux3(b_s3), .sel_mux4(b_s4), .en_a(b_ea), .en_b(b_eb), .en_rem(b_er),
    .rm(b_rm), .busy(b_bz), .done(b_dn), .iter(b_it));

  fpdiv_seq #(.ITER(15)) u15 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .rm_in(rm_in),
    .sel_mux3(c_s3), .sel_mux4(c_s4), .en_a(c_ea), .en_b(c_eb), .en_rem(c_er),
    .rm(c_rm), .busy(c_bz), .done(c_dn), .iter(c_it));

  logic [13:0] obs [3];
  assign obs[0] = {a_s3, a_s4, a_ea, a_eb, a_er, a_rm, a_bz, a_dn, 1'b0, a_it};
  assign obs[1] = {b_s3, b_s4, b_ea, b_eb, b_er, b_rm, b_bz, b_dn, 2'b0, b_it};
  assign obs[2] = {c_s3, c_s4, c_ea, c_eb, c_er, c_rm, c_bz, c_dn, c_it};

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1..2N+1 = datapath cycles of the operation,
  // 2N+2 = the done cycle.
  int nit [3] = '{6, 2, 15};
  int ph  [3] = '{0, 0, 0};
  bit mrm [3] = '{1'b0, 1'b0, 1'b0};
  bit armed = 1'b0;

  function automatic logic [13:0] expect_vec(input int n, input int p, input bit r);
    logic [1:0] s3, s4;
    logic ea, eb, er, bz, dn;
    int it;
    s3 = 2'd0; s4 = 2'd0; ea = 1'b0; eb = 1'b0; er = 1'b0;
    if (p == 1) begin
      s4 = 2'd0; s3 = 2'd0; ea = 1'b1;
    end else if (p == 2) begin
      s4 = 2'd1; s3 = 2'd0; eb = 1'b1;
    end else if (p >= 3 && p <= 2 * n) begin
      s3 = 2'd1;
      if (p % 2 == 1) begin s4 = 2'd2; ea = 1'b1; end
      else            begin s4 = 2'd3; eb = 1'b1; end
    end else if (p == 2 * n + 1) begin
      s4 = 2'd2; s3 = 2'd2; er = 1'b1;
    end
    bz = (p >= 1 && p <= 2 * n + 1);
    dn = (p == 2 * n + 2);
    it = (p >= 1 && p <= 2 * n) ? (p + 1) / 2 : 0;
    return {s3, s4, ea, eb, er, r, bz, dn, 4'(it)};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        ph[i] = 0;
        mrm[i] = 1'b0;
      end else if (ph[i] == 0 || ph[i] == 2 * nit[i] + 2) begin
        if (start) begin
          ph[i] = 1;
          mrm[i] = rm_in;
        end else begin
          ph[i] = 0;
        end
      end else if (kill) begin
        ph[i] = 0;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        logic [13:0] e;
        e = expect_vec(nit[i], ph[i], mrm[i]);
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL model_iter%0d t=%0t got %h want %h", nit[i], $time, obs[i], e);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  int s4lit [13] = '{0, 1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 2};

  initial begin
    int ndone, dcyc, d2c, d15c, mx2, mx15;
    reset = 1'b1; start = 1'b1; kill = 1'b0; rm_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_u6", int'(obs[0]), 0);
    chk("reset_u2", int'(obs[1]), 0);
    chk("reset_u15", int'(obs[2]), 0);
    reset = 1'b0; start = 1'b0; rm_in = 1'b0;
    @(negedge clk);
    chk("idle_u6", int'(obs[0]), 0);

    // Single operation with rm_in = 1, then back-to-back start in DONE.
    start = 1'b1; rm_in = 1'b1;
    @(negedge clk);
    start = 1'b0; rm_in = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 13) chk("single_sel4", int'(a_s4), s4lit[c-1]);
      chk("single_sel3", int'(a_s3), (c <= 2) ? 0 : (c <= 12) ? 1 : (c == 13) ? 2 : 0);
      chk("single_enrem", int'(a_er), (c == 13) ? 1 : 0);
      chk("single_done", int'(a_dn), (c == 14) ? 1 : 0);
      chk("single_rm", int'(a_rm), 1);
      if (c < 14) @(negedge clk);
    end
    start = 1'b1; rm_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_sel4", int'(a_s4), 0);
    chk("b2b_ena", int'(a_ea), 1);
    chk("b2b_busy", int'(a_bz), 1);
    chk("b2b_rm", int'(a_rm), 0);
    chk("b2b_iter", int'(a_it), 1);

    // Start pulsed in cycle 5 of the running operation is ignored.
    repeat (4) @(negedge clk);
    start = 1'b1; rm_in = 1'b1;
    @(negedge clk);
    start = 1'b0; rm_in = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 6; c <= 22; c++) begin
      if (a_dn) begin ndone++; dcyc = c; end
      @(negedge clk);
    end
    chk("ignored_start_ndone", ndone, 1);
    chk("ignored_start_donecyc", dcyc, 14);
    chk("ignored_start_rm", int'(a_rm), 0);
    repeat (40) @(negedge clk);

    // Kill in cycle 7 (IT_N).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", int'(a_bz), 0);
    chk("kill_enables", int'({a_ea, a_eb, a_er}), 0);
    chk("kill_iter", int'(a_it), 0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_dn) ndone++;
      @(negedge clk);
    end
    chk("kill_no_done", ndone, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 30 && dcyc == 0; c++) begin
      if (a_dn) dcyc = c;
      else @(negedge clk);
    end
    chk("after_kill_donecyc", dcyc, 14);
    repeat (40) @(negedge clk);

    // Reset in cycle 4 with start held high.
    start = 1'b1; rm_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midreset_outs", int'(obs[0]), 0);
    @(negedge clk);
    chk("midreset_hold", int'(obs[0]), 0);
    reset = 1'b0; start = 1'b0; rm_in = 1'b0;
    @(negedge clk);
    chk("midreset_after", int'(obs[0]), 0);

    // Parameter sweep: edges from the start edge to done, and iter range.
    start = 1'b1; rm_in = 1'b1;
    @(negedge clk);
    start = 1'b0; rm_in = 1'b0;
    chk("sweep_first_iter_u2", int'(b_it), 1);
    chk("sweep_first_iter_u15", int'(c_it), 1);
    d2c = 0; d15c = 0; mx2 = 0; mx15 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (b_dn && d2c == 0) d2c = c;
      if (c_dn && d15c == 0) d15c = c;
      if (int'(b_it) > mx2) mx2 = int'(b_it);
      if (int'(c_it) > mx15) mx15 = int'(c_it);
      @(negedge clk);
    end
    chk("sweep_done_edges_iter2", d2c - 1, 5);
    chk("sweep_done_edges_iter15", d15c - 1, 31);
    chk("sweep_max_iter2", mx2, 2);
    chk("sweep_max_iter15", mx15, 15);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 24) == 0);
      rm_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
